hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Pipeline control block for the 5-stage core; sequences the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Generates stage enables, bubble/flush controls and forwarding selects.
- Runs the data-memory request/ready handshake for the memory op held in EX/MEM. Sits beside the stage registers and drives their enable/flush inputs.
- Control encodings: WB[1]=RegWrite, WB[0]=MemtoReg; MEM[2]=Branch, MEM[1]=MemRead, MEM[0]=MemWrite.

Parameters:
- MEM_TIMEOUT, 16, max cycles in MWAIT before abort (>=2).
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- ifid_rs  in  5  rs of instruction in IF/ID
- ifid_rt  in  5  rt of instruction in IF/ID
- idex_rs  in  5  rs in ID/EX
- idex_rt  in  5  rt in ID/EX
- idex_mem  in  3  MEM control bits in ID/EX
- exmem_wb  in  2  WB control bits in EX/MEM
- exmem_mem  in  3  MEM control bits in EX/MEM
- exmem_rd  in  5  destination register in EX/MEM
- exmem_zero  in  1  ALU zero flag registered with EX/MEM
- memwb_wb  in  2  WB control bits in MEM/WB
- memwb_rd  in  5  destination register in MEM/WB
- dmem_ready  in  1  data memory completion
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables
- ifid_flush, idex_flush  out  1 each  load zero (bubble) on next edge
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- dmem_req  out  1  data memory request
- mem_err  out  1  sticky timeout flag
- stall_cnt, flush_cnt  out  CNT_W each  perf counters (see Optional Feature)

Behaviour:
- Reset (async, immediate): state=RUN, timer=0, mem_err=0, counters=0.
  - While reset is high: all enables=0, flushes=0, dmem_req=0, fwd_a/fwd_b=00.
- Forwarding (combinational, every state), fwd_a:
  - 10 if exmem_wb[1] && exmem_rd!=0 && exmem_rd==idex_rs;
  - else 01 if memwb_wb[1] && memwb_rd!=0 && memwb_rd==idex_rs;
  - else 00. EX/MEM wins when both match.
  - fwd_b: same rules using idex_rt.
- Signals:
  - memop = exmem_mem[1] | exmem_mem[0].
  - taken = exmem_mem[2] & exmem_zero.
  - loaduse = idex_mem[1] && idex_rt!=0 && (idex_rt==ifid_rs || idex_rt==ifid_rt).
- FSM states: RUN, MWAIT, FLUSH.
- RUN, priority memop > taken > loaduse:
  - memop: dmem_req=1.
    - dmem_ready=1 same cycle: single-cycle access; all enables=1; stay RUN.
    - Otherwise: all enables=0; go MWAIT; timer=1.
  - taken: all enables=1; ifid_flush=1; idex_flush=1; go FLUSH.
  - loaduse: pc_en=0, ifid_en=0, idex_flush=1, other enables=1; stay RUN. The stall lasts exactly one cycle.
  - None of the above: all enables=1.
- MWAIT:
  - dmem_req held 1; all enables=0.
  - On dmem_ready=1: enables=1 this cycle; go RUN. If taken also holds, ifid_flush=idex_flush=1 this cycle and go FLUSH instead.
  - Timeout: when timer reaches MEM_TIMEOUT without ready, set mem_err=1, drop dmem_req, enables=1 (op discarded), go RUN.
  - timer increments per MWAIT cycle and saturates.
- FLUSH: one cycle; all enables=1; ifid_flush=idex_flush=1; go RUN. loaduse is ignored in this cycle because the bubbles are invalid.
- mem_err: sticky; cleared only by reset.
- Reset mid-MWAIT: dmem_req drops immediately; no completion is tracked afterwards.
- dmem_ready while dmem_req=0 is ignored.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with pc_en=0 while reset is low.
  - flush_cnt increments on every cycle with ifid_flush=1.
  - Both saturate at all-ones.
- Undefined: no counter registers; stall_cnt and flush_cnt tied to 0.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum (RUN=2'd0, MWAIT=2'd1, FLUSH=2'd2);
  - FWD_REG/FWD_MEM/FWD_EX constants;
  - WB/MEM bit-index constants (WB_REGWRITE=1, MEM_BRANCH=2, MEM_READ=1, MEM_WRITE=0).
- Sub-module fwd_unit: purely combinational forwarding selects, instantiated once.

Test Plan:
- EX/MEM rd=5 RegWrite=1, MEM/WB rd=5 RegWrite=1, idex_rs=5 -> fwd_a=10; set exmem_rd=0 -> fwd_a=01.
- lw with idex_rt=3, ifid_rs=3 -> exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables=1.
- exmem_mem=010, dmem_ready low 3 cycles then high -> dmem_req high 4 cycles, enables=0 for 3 cycles, =1 on ready cycle.
- Branch with zero=1 -> ifid_flush=idex_flush=1 for 2 consecutive cycles (RUN edge + FLUSH), then RUN.
- MEM_TIMEOUT=4, dmem_ready never asserted -> mem_err=1 after 4 MWAIT cycles, dmem_req drops, mem_err stays 1 until reset.
- Assert reset during MWAIT -> dmem_req=0 and state=RUN immediately, without waiting for a clock edge. With HAZARD_PERF_CNT_EN defined, counters read 0 after reset.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer and its
// forwarding unit: FSM state encoding, forwarding selects, control-bit indices.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  localparam int WB_REGWRITE = 1;
  localparam int MEM_BRANCH  = 2;
  localparam int MEM_READ    = 1;
  localparam int MEM_WRITE   = 0;

  // The younger writer (EX/MEM) shadows the older one (MEM/WB); r0 never forwards.
  function automatic logic [1:0] fwd_select(input logic       ex_wr,
                                            input logic [4:0] ex_rd,
                                            input logic       mem_wr,
                                            input logic [4:0] mem_rd,
                                            input logic [4:0] src);
    if (ex_wr && (ex_rd != 5'd0) && (ex_rd == src))
      return FWD_EX;
    else if (mem_wr && (mem_rd != 5'd0) && (mem_rd == src))
      return FWD_MEM;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational ALU operand forwarding selects for the instruction in ID/EX.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic       exmem_regwrite,
  input  logic [4:0] exmem_rd,
  input  logic       memwb_regwrite,
  input  logic [4:0] memwb_rd,
  input  logic [4:0] idex_rs,
  input  logic [4:0] idex_rt,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_select(exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd, idex_rs);
  assign fwd_b = fwd_select(exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd, idex_rt);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline control for the 5-stage core: stage enables, bubbles, forwarding and
// the data-memory handshake. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic [2:0]       idex_mem,
  input  logic [1:0]       exmem_wb,
  input  logic [2:0]       exmem_mem,
  input  logic [4:0]       exmem_rd,
  input  logic             exmem_zero,
  input  logic [1:0]       memwb_wb,
  input  logic [4:0]       memwb_rd,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              TMR_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             mem_err_q, mem_err_d;
  logic             lu_hold_q, lu_hold_d;

  logic       memop, taken, loaduse;
  logic       en_all, front_stall, ifid_flush_c, idex_flush_c, dmem_req_c;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       unused_wb_bits;

  assign unused_wb_bits = exmem_wb[0] ^ memwb_wb[0];

  fwd_unit u_fwd (
    .exmem_regwrite (exmem_wb[WB_REGWRITE]),
    .exmem_rd       (exmem_rd),
    .memwb_regwrite (memwb_wb[WB_REGWRITE]),
    .memwb_rd       (memwb_rd),
    .idex_rs        (idex_rs),
    .idex_rt        (idex_rt),
    .fwd_a          (fwd_a_raw),
    .fwd_b          (fwd_b_raw)
  );

  assign memop   = exmem_mem[MEM_READ] | exmem_mem[MEM_WRITE];
  assign taken   = exmem_mem[MEM_BRANCH] & exmem_zero;
  assign loaduse = idex_mem[MEM_READ] && (idex_rt != 5'd0) &&
                   ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

  // lu_hold_q remembers that the previous cycle was a load-use stall, so the
  // same hazard never stalls twice even if ID/EX was not yet refilled.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    mem_err_d    = mem_err_q;
    lu_hold_d    = 1'b0;
    en_all       = 1'b1;
    front_stall  = 1'b0;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    dmem_req_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (memop) begin
          dmem_req_c = 1'b1;
          if (!dmem_ready) begin
            en_all  = 1'b0;
            state_d = MWAIT;
            timer_d = TMR_W'(1);
          end
        end else if (taken) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          state_d      = FLUSH;
        end else if (loaduse && !lu_hold_q) begin
          front_stall  = 1'b1;
          idex_flush_c = 1'b1;
          lu_hold_d    = 1'b1;
        end
      end
      MWAIT: begin
        if (timer_q >= TMR_LIMIT) begin
          mem_err_d = 1'b1;
          state_d   = RUN;
        end else begin
          dmem_req_c = 1'b1;
          if (dmem_ready) begin
            if (taken) begin
              ifid_flush_c = 1'b1;
              idex_flush_c = 1'b1;
              state_d      = FLUSH;
            end else begin
              state_d = RUN;
            end
          end else begin
            en_all  = 1'b0;
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      FLUSH: begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
        state_d      = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Reset forces every control output quiet without waiting for a clock edge.
  always_comb begin
    pc_en      = ~reset & en_all & ~front_stall;
    ifid_en    = ~reset & en_all & ~front_stall;
    idex_en    = ~reset & en_all;
    exmem_en   = ~reset & en_all;
    memwb_en   = ~reset & en_all;
    ifid_flush = ~reset & ifid_flush_c;
    idex_flush = ~reset & idex_flush_c;
    dmem_req   = ~reset & dmem_req_c;
    fwd_a      = reset ? FWD_REG : fwd_a_raw;
    fwd_b      = reset ? FWD_REG : fwd_b_raw;
  end

  assign mem_err = mem_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      timer_q   <= '0;
      mem_err_q <= 1'b0;
      lu_hold_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mem_err_q <= mem_err_d;
      lu_hold_q <= lu_hold_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && !reset && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
